// File: rtl/nr4sd_pp_accumulator.sv
// Sequential NR4SD radix-4 partial-product generator/accumulator, one digit per handshake, LSD first.
// Optional NR4SD_DIGIT_CHECK_EN: multi-hot digits count as zero and raise a sticky err flag.
module nr4sd_pp_accumulator #(
  parameter int unsigned W    = 8,
  parameter int unsigned NDIG = W / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     multiplicand,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic             one_p,
  input  logic             one_m,
  input  logic             two_p,
  input  logic             two_m,
  output logic [2*W-1:0]   product,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned XW = W + 2;
  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [W-1:0]  a_q, a_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] product_nxt;
  logic          rdy_nxt, busy_nxt, done_nxt;

  logic          d_zero, d_two, d_neg;
  logic [XW-1:0] a_x, mag, pp;
  logic [PW-1:0] pp_ext, pp_sh;

`ifdef NR4SD_DIGIT_CHECK_EN
  logic d_bad;
  logic err_q, err_nxt;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Digit decode into zero / magnitude-two / negate controls
  always_comb begin
    d_zero = 1'b1;
    d_two  = 1'b0;
    d_neg  = 1'b0;
`ifdef NR4SD_DIGIT_CHECK_EN
    d_bad  = 1'b0;
    case ({two_m, two_p, one_m, one_p})
      4'b0000: d_zero = 1'b1;
      4'b0001: d_zero = 1'b0;
      4'b0010: begin d_zero = 1'b0; d_neg = 1'b1; end
      4'b0100: begin d_zero = 1'b0; d_two = 1'b1; end
      4'b1000: begin d_zero = 1'b0; d_two = 1'b1; d_neg = 1'b1; end
      default: d_bad = 1'b1;
    endcase
`else
    if (two_m) begin
      d_zero = 1'b0; d_two = 1'b1; d_neg = 1'b1;
    end else if (two_p) begin
      d_zero = 1'b0; d_two = 1'b1;
    end else if (one_m) begin
      d_zero = 1'b0; d_neg = 1'b1;
    end else if (one_p) begin
      d_zero = 1'b0;
    end
`endif
  end

  // d*A at W+2 bits, sign-extended to 2W and aligned to the digit weight
  assign a_x    = {{2{a_q[W-1]}}, a_q};
  assign mag    = d_two ? (a_x << 1) : a_x;
  assign pp     = d_zero ? '0 : (d_neg ? (~mag + XW'(1)) : mag);
  assign pp_ext = {{(PW-XW){pp[XW-1]}}, pp};
  assign pp_sh  = pp_ext << {cnt, 1'b0};

  always_comb begin
    state_nxt   = state;
    a_nxt       = a_q;
    cnt_nxt     = cnt;
    product_nxt = product;
    rdy_nxt     = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
`ifdef NR4SD_DIGIT_CHECK_EN
    err_nxt     = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          a_nxt       = multiplicand;
          product_nxt = '0;
          cnt_nxt     = '0;
`ifdef NR4SD_DIGIT_CHECK_EN
          err_nxt     = 1'b0;
`endif
          state_nxt   = S_ACC;
          rdy_nxt     = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      S_ACC: begin
        rdy_nxt  = 1'b1;
        busy_nxt = 1'b1;
        if (dig_valid && dig_ready) begin
          product_nxt = product + pp_sh;
          cnt_nxt     = cnt + CW'(1);
`ifdef NR4SD_DIGIT_CHECK_EN
          if (d_bad) err_nxt = 1'b1;
`endif
          if (cnt == CW'(NDIG - 1)) begin
            state_nxt = S_DONE;
            rdy_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      cnt       <= '0;
      product   <= '0;
      dig_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef NR4SD_DIGIT_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      a_q       <= a_nxt;
      cnt       <= cnt_nxt;
      product   <= product_nxt;
      dig_ready <= rdy_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
`ifdef NR4SD_DIGIT_CHECK_EN
      err_q     <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_nr4sd_pp_accumulator.sv
// Scoreboard bench for nr4sd_pp_accumulator (W=8): expected {err, product} queued at start, checked on done.
module tb_nr4sd_pp_accumulator;

  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] P1 = 4'b0001;
  localparam logic [3:0] M1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] M2 = 4'b1000;
  localparam logic [3:0] MH = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic        dig_valid;
  logic        dig_ready;
  logic        one_p, one_m, two_p, two_m;
  logic [15:0] product;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  nr4sd_pp_accumulator #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
    .dig_valid(dig_valid), .dig_ready(dig_ready),
    .one_p(one_p), .one_m(one_m), .two_p(two_p), .two_m(two_m),
    .product(product), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dval(input logic [3:0] s);
`ifdef NR4SD_DIGIT_CHECK_EN
    if ($countones(s) > 1) return 0;
`endif
    if (s[3]) return -2;
    if (s[2]) return 2;
    if (s[1]) return -1;
    if (s[0]) return 1;
    return 0;
  endfunction

  function automatic bit dbad(input logic [3:0] s);
`ifdef NR4SD_DIGIT_CHECK_EN
    return $countones(s) > 1;
`else
    return (s == 4'hF) && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] nr4sd_m(input int unsigned r);
    case (r % 4)
      0: return M2;
      1: return M1;
      2: return Z;
      default: return P1;
    endcase
  endfunction

  task automatic set_sel(input logic [3:0] s);
    {two_m, two_p, one_m, one_p} = s;
  endtask

  // Drives one operation; abort asserts rst after two accepted digits
  task automatic run_op(input logic [7:0] a, input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3, input int stall,
                        input bit start_in_acc, input bit start_in_done, input bit abort);
    logic [3:0]  ds[4];
    int          av, acc, tot;
    bit          e, etot;
    logic [15:0] part;
    ds = '{d0, d1, d2, d3};
    av = int'($signed(a));
    tot = 0; etot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tot += dval(ds[i]) * (1 << (2 * i));
      etot |= dbad(ds[i]);
    end
    acc = 0; e = 1'b0; part = '0;

    @(posedge clk); #1;
    start = 1'b1; multiplicand = a;
    @(posedge clk); #1;
    start = 1'b0; multiplicand = 8'($urandom);
    if (!abort) exp_q.push_back({etot, 16'(av * tot)});
    check("start_busy", 32'(busy), 32'd1);
    check("start_clear", 32'(product), 32'd0);
    check("start_err", 32'(err), 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (abort && i == 2) begin
        #2 rst = 1'b1;
        #1;
        check("arst_product", 32'(product), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(dig_ready), 32'd0);
        #1 rst = 1'b0;
        dig_valid = 1'b0; set_sel(Z);
        return;
      end
      if (i > 0) begin
        dig_valid = 1'b0; set_sel(4'($urandom));
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          check("stall_hold", 32'(product), 32'(part));
        end
      end
      dig_valid = 1'b1; set_sel(ds[i]);
      if (start_in_acc && i == 1) begin
        start = 1'b1; multiplicand = 8'h7F;
      end
      check("ready", 32'(dig_ready), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      acc += dval(ds[i]) * (1 << (2 * i));
      e |= dbad(ds[i]);
      part = 16'(av * acc);
      if (i < 3) begin
        check("partial", 32'(product), 32'(part));
        check("no_early_done", 32'(done), 32'd0);
      end
    end
    dig_valid = 1'b0; set_sel(Z);
    check("done_latency", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_ready", 32'(dig_ready), 32'd0);
    if (start_in_done) begin
      start = 1'b1; multiplicand = 8'h11;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_err", 32'(err), 32'(e));
    check("idle_hold", 32'(product), 32'(part));
  endtask

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [16:0] ex;
        ex = exp_q.pop_front();
        check("product", 32'(product), 32'(ex[15:0]));
        check("err", 32'(err), 32'(ex[16]));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; multiplicand = '0; dig_valid = 1'b0; set_sel(Z);
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", 32'(product), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(dig_ready), 32'd0);
    rst = 1'b0;

    run_op(8'h07, P1, P2, M1, Z,  0, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, Z,  Z,  Z,  P2, 0, 1'b0, 1'b1, 1'b0);
    run_op(8'h55, M2, P1, P1, M1, 3, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, P1, Z,  Z,  Z,  0, 1'b1, 1'b0, 1'b0);
    run_op(8'h09, P1, P2, P1, Z,  0, 1'b0, 1'b0, 1'b1);
    run_op(8'h21, M1, P1, P2, M2, 1, 1'b0, 1'b0, 1'b0);
    run_op(8'h05, P1, MH, Z,  Z,  0, 1'b0, 1'b0, 1'b0);
    run_op(8'hB3, P2, M2, P1, M1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_op(8'($urandom), nr4sd_m($urandom), nr4sd_m($urandom), nr4sd_m($urandom),
             nr4sd_m($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
